bram_capture_addr: RTL and testbench
====================================

# bram_capture_addr

Parametrised BRAM write-address generator for acquisition capture, the successor to the free-running address counter. It waits for a rising edge on a trigger, then drives a BRAM write port with a word-incrementing byte address and a full-width write enable for a programmable number of samples. It runs in one-shot mode (stop and flag done) or continuous mode (wrap and pulse). It sits between the ADC sample stream and a BRAM port-A controller, with status read back by the PS.

## Interface
- COUNT_WIDTH, 14, word-index width; maximum depth 2^COUNT_WIDTH words
- DATA_BYTES, 4, bytes per BRAM word; power of two, 1..16
- ADDR_WIDTH, 32, width of the `address` and `address_dbg` outputs; must be ≥ COUNT_WIDTH + log2(DATA_BYTES)

- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- trig  in  1  capture trigger; only its rising edge acts
- stop  in  1  level; aborts an active capture
- cfg_mode  in  1  0 = one-shot, 1 = continuous
- cfg_last  in  COUNT_WIDTH  index of the last word (capture length is cfg_last + 1)
- address  out  ADDR_WIDTH  byte address: count << log2(DATA_BYTES), zero-extended
- address_dbg  out  ADDR_WIDTH  word index `count`, zero-extended
- wen  out  DATA_BYTES  write enable, all bits equal
- busy  out  1  high while in CAPTURE
- done  out  1  high while in DONE
- wrap  out  1  one-cycle pulse on continuous-mode wrap

## Operation
- The edge detector registers `trig` into `trig_q`. An edge is `trig & ~trig_q`.
- `trig_q` resets to 1, so a `trig` held high through reset does not start a capture.
- **IDLE**: count = 0, wen = 0. On an edge with stop = 0, latch cfg_mode and cfg_last into shadow registers and go to CAPTURE.
- **CAPTURE**: wen is all ones. Each cycle, count increments by 1.
  - When count equals the latched last value in one-shot mode: go to DONE; count holds at last.
  - When count equals the latched last value in continuous mode: count goes to 0, `wrap` pulses, and the state stays CAPTURE.
  - Trigger edges are ignored in CAPTURE.
- **DONE**: wen = 0, count holds, done = 1. An edge with stop = 0 re-latches the configuration, clears count to 0 and goes to CAPTURE.
- **stop = 1**:
  - In CAPTURE: next state is IDLE, count = 0, done stays 0.
  - In IDLE or DONE: blocks starts. DONE stays DONE.
- **Simultaneous events**:
  - stop and an edge in the same cycle: stop wins.
  - The last-index match and stop in the same cycle: stop wins (IDLE; no done, no wrap).
- Changes to cfg_* during CAPTURE have no effect until the next start.
- cfg_last = 0 gives a single-word capture. In continuous mode it rewrites word 0 every cycle and pulses wrap every cycle.
- **Reset**: state IDLE, count 0, wen 0, busy 0, done 0, wrap 0, address 0, address_dbg 0, trig_q 1.

## Timing
- All outputs are registered and change only on the rising edge of clk.
- Edge sampled at cycle t → busy = 1, wen = all ones, count = 0 at t+1. Trigger-to-first-write latency is 1 cycle.
- One-shot capture of N = cfg_last + 1 words: wen is high for exactly N consecutive cycles, t+1 .. t+N, with count 0 .. N-1. From t+N+1: done = 1, wen = 0, count = N-1.
- Continuous mode: wrap is high in the cycle where count = 0 following count = last. The first entry at t+1 does not pulse wrap.
- stop sampled at cycle s during CAPTURE: wen = 0 and count = 0 at s+1. The last write occurs at cycle s.
- No gap cycles: a restart from DONE gives wen = 1 at the cycle after the edge.

## Structure
- Package `bram_capture_pkg`:
  - state enum: IDLE, CAPTURE, DONE
  - localparam BYTE_SHIFT = $clog2(DATA_BYTES) as a function of DATA_BYTES
  - mode constants MODE_ONESHOT = 0, MODE_CONT = 1
- Sub-module `trig_edge_detect`: registered rising-edge detector with a parameterised reset value of `trig_q`. Reused by other trigger-driven cores.
- Top level: FSM, counter, shadow configuration registers, output registers. Target 150–250 lines.

## Test plan
- **Reset with trig held high**: release rst with trig = 1 for 5 cycles → no capture; busy = 0, wen = 0, address = 0.
- **One-shot, DATA_BYTES = 4, cfg_last = 7**: drive a trig edge → wen = 0xF for exactly 8 cycles; address = 0, 4, …, 28; then done = 1, address_dbg = 7, wen = 0. A second edge restarts with address = 0.
- **Continuous, cfg_last = 3**: after the edge → address_dbg cycles 0,1,2,3,0,…; wrap is high on each return to 0 except the first; trig edges during capture are ignored.
- **Stop during capture at count = 5**: → next cycle state IDLE, count = 0, wen = 0, done = 0. Stop and trig asserted together in IDLE → no start.
- **Wrap at full depth, COUNT_WIDTH = 4, cfg_last = 15, continuous**: → count 15 → 0 with a wrap pulse. Changing cfg_last mid-capture to 2 has no effect until a restart.
- **cfg_last = 0, one-shot**: → wen is high for 1 cycle at address 0, then done = 1.

Source files
------------

// File: rtl/bram_capture_addr_pkg.sv
// bram_capture_pkg: shared state encoding, mode constants and byte-shift helper for the capture address generator
package bram_capture_pkg;
  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_CONT = 1'b1;
  function automatic int byte_shift(input int data_bytes);
    return $clog2(data_bytes);
  endfunction
endpackage

// File: rtl/bram_capture_addr_trig_edge_detect.sv
// trig_edge_detect: registered rising-edge detector with configurable reset value of the delayed trigger
module trig_edge_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_trig,
  output logic o_rise
);
  logic r_trig_q;
  always_ff @(posedge clk)
    if (rst) r_trig_q <= RST_VAL;
    else r_trig_q <= i_trig;
  assign o_rise = i_trig & ~r_trig_q;
endmodule

// File: rtl/bram_capture_addr.sv
// bram_capture_addr: triggered BRAM write-address generator with one-shot and continuous capture
module bram_capture_addr
  import bram_capture_pkg::*;
#(
  parameter int COUNT_WIDTH = 14,
  parameter int DATA_BYTES = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   trig,
  input  logic                   stop,
  input  logic                   cfg_mode,
  input  logic [COUNT_WIDTH-1:0] cfg_last,
  output logic [ADDR_WIDTH-1:0]  address,
  output logic [ADDR_WIDTH-1:0]  address_dbg,
  output logic [DATA_BYTES-1:0]  wen,
  output logic                   busy,
  output logic                   done,
  output logic                   wrap
);
  localparam int BYTE_SHIFT = byte_shift(DATA_BYTES);
  state_t r_state, w_state;
  logic [COUNT_WIDTH-1:0] r_count, w_count, r_last;
  logic r_mode, r_busy, r_done, r_wrap;
  logic w_rise, w_start, w_latch, w_wrap;
  // trig_q resets high so a trigger already asserted during reset is not seen as an edge
  trig_edge_detect #(.RST_VAL(1'b1)) u_edge (
    .clk(clk),
    .rst(rst),
    .i_trig(trig),
    .o_rise(w_rise)
  );
  assign w_start = w_rise & ~stop;
  always_comb begin
    w_state = r_state;
    w_count = r_count;
    w_wrap = 1'b0;
    w_latch = 1'b0;
    case (r_state)
      IDLE, DONE: if (w_start) begin
        w_state = CAPTURE;
        w_count = '0;
        w_latch = 1'b1;
      end
      CAPTURE: if (stop) begin
        w_state = IDLE;
        w_count = '0;
      end else if (r_count == r_last) begin
        w_state = (r_mode == MODE_CONT) ? CAPTURE : DONE;
        w_count = (r_mode == MODE_CONT) ? '0 : r_count;
        w_wrap = (r_mode == MODE_CONT);
      end else w_count = r_count + 1'b1;
      default: begin
        w_state = IDLE;
        w_count = '0;
      end
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_last <= '0;
      r_mode <= MODE_ONESHOT;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      r_state <= w_state;
      r_count <= w_count;
      if (w_latch) begin
        r_mode <= cfg_mode;
        r_last <= cfg_last;
      end
      r_busy <= (w_state == CAPTURE);
      r_done <= (w_state == DONE);
      r_wrap <= w_wrap;
    end
  assign address = ADDR_WIDTH'(r_count) << BYTE_SHIFT;
  assign address_dbg = ADDR_WIDTH'(r_count);
  assign wen = {DATA_BYTES{r_busy}};
  assign busy = r_busy;
  assign done = r_done;
  assign wrap = r_wrap;
endmodule

// File: tb/tb_bram_capture_addr.sv
// tb_bram_capture_addr: directed stimulus checked every cycle against a behavioural capture model plus literal spot checks
module tb_bram_capture_addr;
  localparam int CW = 4;
  localparam int DB = 4;
  localparam int AW = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic trig = 1'b1;
  logic stop = 1'b0;
  logic cfg_mode = 1'b0;
  logic [CW-1:0] cfg_last = '0;
  logic [AW-1:0] address, address_dbg;
  logic [DB-1:0] wen;
  logic busy, done, wrap;
  int errors = 0;
  int checks = 0;
  int m_idx = 0;
  int m_len = 1;
  bit m_busy = 0, m_done = 0, m_wrap = 0, m_cont = 0, m_tq = 1;
  int nwrap;

  bram_capture_addr #(.COUNT_WIDTH(CW), .DATA_BYTES(DB), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .trig(trig), .stop(stop), .cfg_mode(cfg_mode), .cfg_last(cfg_last),
    .address(address), .address_dbg(address_dbg), .wen(wen), .busy(busy), .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // capture model: a run of m_len words from index 0, either stopping on the last word or restarting
  always @(posedge clk) begin
    bit start;
    start = trig && !m_tq && !stop;
    m_wrap = 0;
    if (rst) begin
      m_busy = 0; m_done = 0; m_idx = 0; m_tq = 1;
    end else begin
      if (m_busy) begin
        if (stop) begin
          m_busy = 0; m_idx = 0;
        end else if (m_idx + 1 == m_len) begin
          if (m_cont) begin m_idx = 0; m_wrap = 1; end
          else begin m_busy = 0; m_done = 1; end
        end else m_idx = m_idx + 1;
      end else if (start) begin
        m_busy = 1; m_done = 0; m_idx = 0; m_len = int'(cfg_last) + 1; m_cont = cfg_mode;
      end
      m_tq = trig;
    end
  end

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    chk("model_busy", AW'(busy), AW'(m_busy));
    chk("model_done", AW'(done), AW'(m_done));
    chk("model_wrap", AW'(wrap), AW'(m_wrap));
    chk("model_wen", AW'(wen), m_busy ? AW'(4'hF) : '0);
    chk("model_address", address, AW'(m_idx * DB));
    chk("model_address_dbg", address_dbg, AW'(m_idx));
  endtask

  initial begin
    repeat (3) cyc();
    chk("reset_busy", AW'(busy), 0);
    chk("reset_address", address, 0);
    rst = 1'b0;
    repeat (5) cyc();
    chk("trig_through_reset_busy", AW'(busy), 0);
    chk("trig_through_reset_wen", AW'(wen), 0);
    chk("trig_through_reset_address", address, 0);
    trig = 0; cyc();
    cfg_mode = 0; cfg_last = 7; trig = 1; cyc();
    chk("oneshot_first_wen", AW'(wen), 32'hF);
    chk("oneshot_first_address", address, 0);
    trig = 0;
    for (int i = 1; i < 8; i++) begin
      cyc();
      chk("oneshot_address", address, AW'(i * 4));
    end
    cyc();
    chk("oneshot_done", AW'(done), 1);
    chk("oneshot_done_wen", AW'(wen), 0);
    chk("oneshot_done_dbg", address_dbg, 7);
    trig = 1; cyc();
    chk("restart_address", address, 0);
    chk("restart_busy", AW'(busy), 1);
    chk("restart_done", AW'(done), 0);
    trig = 0; repeat (8) cyc();
    chk("restart_done_again", AW'(done), 1);
    cfg_mode = 1; cfg_last = 3; trig = 1; cyc();
    chk("cont_first_wrap", AW'(wrap), 0);
    nwrap = 0;
    for (int k = 1; k < 12; k++) begin
      trig = k[0];
      cyc();
      chk("cont_dbg", address_dbg, AW'(k % 4));
      nwrap += int'(wrap);
    end
    chk("cont_wrap_count", AW'(nwrap), 2);
    stop = 1; cyc();
    chk("cont_stop_busy", AW'(busy), 0);
    stop = 0; trig = 0; cfg_mode = 0; cfg_last = 9; cyc();
    trig = 1; cyc();
    trig = 0; repeat (5) cyc();
    chk("stop_at5_dbg_before", address_dbg, 5);
    stop = 1; cyc();
    chk("stop_busy", AW'(busy), 0);
    chk("stop_wen", AW'(wen), 0);
    chk("stop_done", AW'(done), 0);
    chk("stop_dbg", address_dbg, 0);
    trig = 1; cyc();
    chk("stop_and_trig_idle", AW'(busy), 0);
    stop = 0; trig = 0; repeat (2) cyc();
    chk("idle_after_stop", AW'(busy), 0);
    cfg_mode = 1; cfg_last = 15; trig = 1; cyc();
    trig = 0; cfg_last = 2;
    repeat (15) cyc();
    chk("full_depth_dbg15", address_dbg, 15);
    cyc();
    chk("full_depth_wrap", AW'(wrap), 1);
    chk("full_depth_dbg0", address_dbg, 0);
    repeat (3) cyc();
    chk("cfg_change_ignored", address_dbg, 3);
    stop = 1; cyc();
    stop = 0; trig = 1; cyc();
    trig = 0; repeat (3) cyc();
    chk("new_last_wrap", AW'(wrap), 1);
    chk("new_last_dbg", address_dbg, 0);
    stop = 1; cyc();
    stop = 0; cfg_mode = 0; cfg_last = 0; trig = 1; cyc();
    chk("single_wen", AW'(wen), 32'hF);
    chk("single_address", address, 0);
    trig = 0; cyc();
    chk("single_done", AW'(done), 1);
    chk("single_done_wen", AW'(wen), 0);
    stop = 1; cyc();
    chk("done_holds_under_stop", AW'(done), 1);
    stop = 0; cfg_mode = 1; trig = 1; cyc();
    chk("cont0_first_wrap", AW'(wrap), 0);
    trig = 0; cyc();
    chk("cont0_wrap", AW'(wrap), 1);
    cyc();
    chk("cont0_wrap_again", AW'(wrap), 1);
    stop = 1; cyc();
    chk("stop_beats_last_wrap", AW'(wrap), 0);
    chk("stop_beats_last_done", AW'(done), 0);
    stop = 0; repeat (2) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
